// File: rtl/execute_stage_if.sv
// Execute-stage bus bundle: everything the execute stage exchanges with the
// D/E register, the forwarding paths, the hazard unit and the E/M register.
// The master modport is the pipeline surrounding the stage; the slave modport
// is the execute stage itself.
interface execute_stage_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int RF_ADDR_WIDTH = 5
);
   // Operands and control from the D/E register
   logic [DATA_WIDTH-1:0]    i_SrcAE;
   logic [DATA_WIDTH-1:0]    i_SrcBE;
   logic [DATA_WIDTH-1:0]    i_SignImmE;
   logic [RF_ADDR_WIDTH-1:0] i_RtE;
   logic [RF_ADDR_WIDTH-1:0] i_RdE;
   logic [4:0]               i_ShamtE;
   logic [2:0]               i_ALUControlE;
   logic                     i_ALUSrcE;
   logic                     i_RegDstE;
   logic                     i_MulStartE;
   logic                     i_MulSignedE;
   logic [1:0]               i_HiLoSelE;

   // Forwarding selects and forwarded values
   logic [1:0]               i_ForwardAE;
   logic [1:0]               i_ForwardBE;
   logic [DATA_WIDTH-1:0]    i_ALUOutM;
   logic [DATA_WIDTH-1:0]    i_ResultW;

   // Results towards the E/M register and the hazard unit
   logic [DATA_WIDTH-1:0]    o_ALUOutE;
   logic [DATA_WIDTH-1:0]    o_WriteDataE;
   logic [RF_ADDR_WIDTH-1:0] o_WriteRegE;
   logic                     o_ZeroE;
   logic                     o_MulBusyE;
   logic                     o_StallE;

   modport master (
      output i_SrcAE, i_SrcBE, i_SignImmE, i_RtE, i_RdE, i_ShamtE,
             i_ALUControlE, i_ALUSrcE, i_RegDstE, i_MulStartE, i_MulSignedE,
             i_HiLoSelE, i_ForwardAE, i_ForwardBE, i_ALUOutM, i_ResultW,
      input  o_ALUOutE, o_WriteDataE, o_WriteRegE, o_ZeroE, o_MulBusyE,
             o_StallE
   );

   modport slave (
      input  i_SrcAE, i_SrcBE, i_SignImmE, i_RtE, i_RdE, i_ShamtE,
             i_ALUControlE, i_ALUSrcE, i_RegDstE, i_MulStartE, i_MulSignedE,
             i_HiLoSelE, i_ForwardAE, i_ForwardBE, i_ALUOutM, i_ResultW,
      output o_ALUOutE, o_WriteDataE, o_WriteRegE, o_ZeroE, o_MulBusyE,
             o_StallE
   );
endinterface

// File: rtl/execute_stage.sv
// MIPS execute stage: operand forwarding, ALUSrc mux, single-cycle ALU,
// RegDst mux and an iterative shift-add multiplier (one partial product per
// clock, DATA_WIDTH iterations) feeding the HI/LO registers.
// Optional feature macro MUL_SIGNED_EN: when defined, i_MulSignedE selects
// MULT (signed) semantics; when undefined every multiply is MULTU and no sign
// logic is built.
module execute_stage #(
   parameter int DATA_WIDTH    = 32,
   parameter int RF_ADDR_WIDTH = 5,
   parameter int MUL_CNT_WIDTH = 6
) (
   input logic            i_CLK,
   input logic            i_RST,
   execute_stage_if.slave bus
);

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SLL = 3'b011;
   localparam logic [2:0] ALU_SRL = 3'b100;
   localparam logic [2:0] ALU_NOR = 3'b101;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SEL_HI = 2'b01;
   localparam logic [1:0] SEL_LO = 2'b10;

   typedef enum logic {IDLE, BUSY} mul_state_t;

   // 00 and 11 both take the register value
   function automatic logic [DATA_WIDTH-1:0] fwd_mux(
      input logic [1:0]            sel,
      input logic [DATA_WIDTH-1:0] reg_val,
      input logic [DATA_WIDTH-1:0] result_w,
      input logic [DATA_WIDTH-1:0] alu_out_m
   );
      case (sel)
         2'b01:   return result_w;
         2'b10:   return alu_out_m;
         default: return reg_val;
      endcase
   endfunction

   logic [DATA_WIDTH-1:0]     src_a;
   logic [DATA_WIDTH-1:0]     fwd_b;
   logic [DATA_WIDTH-1:0]     src_b;
   logic [DATA_WIDTH-1:0]     alu_result;

   mul_state_t                state_q, state_d;
   logic [MUL_CNT_WIDTH-1:0]  cnt_q;
   logic [2*DATA_WIDTH-1:0]   mcand_q;
   logic [DATA_WIDTH-1:0]     mplier_q;
   logic [2*DATA_WIDTH-1:0]   acc_q;
   logic [DATA_WIDTH-1:0]     hi_q, lo_q;

   logic [DATA_WIDTH-1:0]     mag_a, mag_b;
   logic [2*DATA_WIDTH-1:0]   acc_next;
   logic [2*DATA_WIDTH-1:0]   product;
   logic                      mul_load;
   logic                      mul_done;

   assign src_a = fwd_mux(bus.i_ForwardAE, bus.i_SrcAE, bus.i_ResultW, bus.i_ALUOutM);
   assign fwd_b = fwd_mux(bus.i_ForwardBE, bus.i_SrcBE, bus.i_ResultW, bus.i_ALUOutM);
   assign src_b = bus.i_ALUSrcE ? bus.i_SignImmE : fwd_b;

   // ALU: shifts act on operand B, add/sub wrap silently
   always_comb begin
      // NOTE: default first so every path assigns alu_result and no latch is inferred.
      alu_result = '0;
      case (bus.i_ALUControlE)
         ALU_AND: alu_result = src_a & src_b;
         ALU_OR:  alu_result = src_a | src_b;
         ALU_ADD: alu_result = src_a + src_b;
         ALU_SUB: alu_result = src_a - src_b;
         ALU_SLT: alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         ALU_SLL: alu_result = src_b << bus.i_ShamtE;
         ALU_SRL: alu_result = src_b >> bus.i_ShamtE;
         ALU_NOR: alu_result = ~(src_a | src_b);
         default: alu_result = '0;
      endcase
   end

   // Operand magnitudes and final sign correction of the product
`ifdef MUL_SIGNED_EN
   logic sign_a, sign_b, neg_q;

   assign sign_a   = bus.i_MulSignedE & src_a[DATA_WIDTH-1];
   assign sign_b   = bus.i_MulSignedE & fwd_b[DATA_WIDTH-1];
   assign mag_a    = sign_a ? -src_a : src_a;
   assign mag_b    = sign_b ? -fwd_b : fwd_b;
   assign product  = neg_q ? -acc_next : acc_next;
`else
   logic unused_mul_signed;

   assign unused_mul_signed = bus.i_MulSignedE;
   assign mag_a    = src_a;
   assign mag_b    = fwd_b;
   assign product  = acc_next;
`endif

   assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign mul_load = (state_q == IDLE) && bus.i_MulStartE;
   assign mul_done = (state_q == BUSY) && (cnt_q == MUL_CNT_WIDTH'(1));

   // Multiplier state register
   always_ff @(posedge i_CLK or negedge i_RST) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (!i_RST) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Multiplier next state: start from IDLE, leave BUSY on the last iteration
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.i_MulStartE) state_d = BUSY;
         BUSY:    if (mul_done)        state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Multiplier datapath: operand latch, shift-add iterations, HI/LO writeback
   always_ff @(posedge i_CLK or negedge i_RST) begin
      if (!i_RST) begin
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
`ifdef MUL_SIGNED_EN
         neg_q    <= 1'b0;
`endif
      end else if (mul_load) begin
         mcand_q  <= {{DATA_WIDTH{1'b0}}, mag_a};
         mplier_q <= mag_b;
         acc_q    <= '0;
         cnt_q    <= MUL_CNT_WIDTH'(DATA_WIDTH);
`ifdef MUL_SIGNED_EN
         neg_q    <= sign_a ^ sign_b;
`endif
      end else if (state_q == BUSY) begin
         acc_q    <= acc_next;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         cnt_q    <= cnt_q - MUL_CNT_WIDTH'(1);
         if (mul_done) {hi_q, lo_q} <= product;
      end
   end

   // Output muxes and hazard-unit handshake
   always_comb begin
      bus.o_WriteDataE = fwd_b;
      bus.o_WriteRegE  = bus.i_RegDstE ? bus.i_RdE : bus.i_RtE;
      bus.o_ZeroE      = (alu_result == '0);
      bus.o_MulBusyE   = (state_q == BUSY);
      bus.o_StallE     = (state_q == BUSY) &&
                         (bus.i_MulStartE || bus.i_HiLoSelE == SEL_HI || bus.i_HiLoSelE == SEL_LO);
      case (bus.i_HiLoSelE)
         SEL_HI:  bus.o_ALUOutE = hi_q;
         SEL_LO:  bus.o_ALUOutE = lo_q;
         default: bus.o_ALUOutE = alu_result;
      endcase
   end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: table-driven combinational vectors
// plus hand-written multiply sequences with a HI/LO scoreboard.
// Expected multiply results follow MUL_SIGNED_EN the same way the design does.
module tb_execute_stage;

   localparam int DW = 32;
   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   execute_stage_if #(.DATA_WIDTH(DW), .RF_ADDR_WIDTH(AW)) bus ();

   execute_stage #(
      .DATA_WIDTH(DW), .RF_ADDR_WIDTH(AW), .MUL_CNT_WIDTH(6)
   ) dut (
      .i_CLK(clk),
      .i_RST(rst_n),
      .bus  (bus)
   );

   typedef struct {
      logic [31:0] srca, srcb, imm, alum, resw;
      logic [1:0]  fa, fb;
      logic        alusrc;
      logic [2:0]  ctl;
      logic [4:0]  shamt, rt, rd;
      logic        regdst;
      logic [1:0]  hilo;
      logic [31:0] exp_out;
      logic        exp_zero;
      logic [31:0] exp_wd;
      logic [4:0]  exp_wr;
   } vec_t;

   int          n_vec  = 0;
   int          n_miss = 0;
   vec_t        vecs[14];
   vec_t        exp_q[$];
   logic [63:0] mul_q[$];
   logic [63:0] last_hilo = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic sgn);
      logic [63:0] ea, eb;
      ea = {32'b0, a};
      eb = {32'b0, b};
`ifdef MUL_SIGNED_EN
      if (sgn) begin
         ea = {{32{a[31]}}, a};
         eb = {{32{b[31]}}, b};
      end
`else
      if (sgn) ea = {32'b0, a};
`endif
      return ea * eb;
   endfunction

   task automatic drive_idle();
      bus.i_SrcAE = '0;       bus.i_SrcBE = '0;     bus.i_SignImmE = '0;
      bus.i_RtE = '0;         bus.i_RdE = '0;       bus.i_ShamtE = '0;
      bus.i_ALUControlE = '0; bus.i_ALUSrcE = 1'b0; bus.i_RegDstE = 1'b0;
      bus.i_MulStartE = 1'b0; bus.i_MulSignedE = 1'b0; bus.i_HiLoSelE = '0;
      bus.i_ForwardAE = '0;   bus.i_ForwardBE = '0;
      bus.i_ALUOutM = '0;     bus.i_ResultW = '0;
   endtask

   // Issue one multiply at a negedge; returns one negedge after the start edge
   task automatic start_mul(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                            input logic [63:0] expected);
      @(negedge clk);
      bus.i_ForwardAE = 2'b00;
      bus.i_ForwardBE = 2'b00;
      bus.i_SrcAE = a;
      bus.i_SrcBE = b;
      bus.i_MulSignedE = sgn;
      bus.i_MulStartE = 1'b1;
      mul_q.push_back(expected);
      @(posedge clk);
      @(negedge clk);
      bus.i_MulStartE = 1'b0;
   endtask

   // Count busy cycles (bounded) and stall errors while the select is held
   task automatic wait_done(input logic [1:0] sel, output int cycles, output int stall_miss);
      logic exp_stall;
      cycles = 0;
      stall_miss = 0;
      bus.i_HiLoSelE = sel;
      exp_stall = (sel == 2'b01) || (sel == 2'b10);
      #1;
      while (bus.o_MulBusyE && cycles < 200) begin
         cycles++;
         if (bus.o_StallE !== exp_stall) stall_miss++;
         @(negedge clk);
         #1;
      end
   endtask

   task automatic check_hilo(input string name);
      logic [63:0] e;
      if (mul_q.size() == 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL %s: scoreboard empty, no expected HI/LO", name);
      end else begin
         e = mul_q.pop_front();
         bus.i_HiLoSelE = 2'b01;
         #1 check({name, "_hi"}, {32'b0, bus.o_ALUOutE}, {32'b0, e[63:32]});
         bus.i_HiLoSelE = 2'b10;
         #1 check({name, "_lo"}, {32'b0, bus.o_ALUOutE}, {32'b0, e[31:0]});
         bus.i_HiLoSelE = 2'b00;
         last_hilo = e;
      end
   endtask

   initial begin
      vec_t        v;
      int          cyc, s_miss, h_miss;
      logic [63:0] exp_signed;

      // srca, srcb, imm, alum, resw, fa, fb, alusrc, ctl, shamt, rt, rd, regdst, hilo,
      // exp_out, exp_zero, exp_wd, exp_wr
      vecs[0]  = '{32'd5, 32'd3, 32'd0, 32'd7, 32'd1, 2'b10, 2'b00, 1'b0, 3'b010, 5'd0, 5'd1, 5'd2, 1'b0, 2'b00,
                   32'd10, 1'b0, 32'd3, 5'd1};
      vecs[1]  = '{32'd5, 32'd3, 32'd0, 32'd7, 32'd1, 2'b01, 2'b00, 1'b0, 3'b010, 5'd0, 5'd1, 5'd2, 1'b1, 2'b00,
                   32'd4, 1'b0, 32'd3, 5'd2};
      vecs[2]  = '{32'd3, 32'd3, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 3'b110, 5'd0, 5'd4, 5'd5, 1'b1, 2'b00,
                   32'd0, 1'b1, 32'd3, 5'd5};
      vecs[3]  = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 3'b111, 5'd0, 5'd6, 5'd7, 1'b0, 2'b00,
                   32'd1, 1'b0, 32'd1, 5'd6};
      vecs[4]  = '{32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 3'b011, 5'd31, 5'd8, 5'd9, 1'b1, 2'b00,
                   32'h8000_0000, 1'b0, 32'd1, 5'd9};
      vecs[5]  = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 3'b010, 5'd0, 5'd10, 5'd11, 1'b0, 2'b00,
                   32'd0, 1'b1, 32'd1, 5'd10};
      vecs[6]  = '{32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 3'b000, 5'd0, 5'd12, 5'd13, 1'b0, 2'b00,
                   32'h00F0_000F, 1'b0, 32'h0FF0_0F0F, 5'd12};
      vecs[7]  = '{32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 3'b001, 5'd0, 5'd12, 5'd13, 1'b1, 2'b00,
                   32'hFFF0_0FFF, 1'b0, 32'h0FF0_0F0F, 5'd13};
      vecs[8]  = '{32'hF0F0_00FF, 32'h0FF0_0F0F, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 3'b101, 5'd0, 5'd14, 5'd15, 1'b0, 2'b00,
                   32'h000F_F000, 1'b0, 32'h0FF0_0F0F, 5'd14};
      vecs[9]  = '{32'd0, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 3'b100, 5'd4, 5'd16, 5'd17, 1'b0, 2'b00,
                   32'h0800_0000, 1'b0, 32'h8000_0000, 5'd16};
      vecs[10] = '{32'd100, 32'd7, 32'hFFFF_FFFC, 32'd0, 32'd0, 2'b00, 2'b00, 1'b1, 3'b010, 5'd0, 5'd18, 5'd19, 1'b0, 2'b00,
                   32'd96, 1'b0, 32'd7, 5'd18};
      vecs[11] = '{32'd20, 32'd99, 32'd0, 32'd8, 32'd0, 2'b00, 2'b10, 1'b0, 3'b110, 5'd0, 5'd20, 5'd21, 1'b1, 2'b00,
                   32'd12, 1'b0, 32'd8, 5'd21};
      vecs[12] = '{32'd6, 32'd2, 32'd0, 32'd7, 32'd1, 2'b11, 2'b11, 1'b0, 3'b010, 5'd0, 5'd22, 5'd23, 1'b0, 2'b11,
                   32'd8, 1'b0, 32'd2, 5'd22};
      vecs[13] = '{32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 3'b111, 5'd0, 5'd24, 5'd25, 1'b1, 2'b00,
                   32'd0, 1'b1, 32'hFFFF_FFFF, 5'd25};

      // Reset state
      drive_idle();
      #2;
      check("reset_busy", {63'b0, bus.o_MulBusyE}, 64'd0);
      check("reset_stall", {63'b0, bus.o_StallE}, 64'd0);
      bus.i_HiLoSelE = 2'b01;
      #1 check("reset_hi", {32'b0, bus.o_ALUOutE}, 64'd0);
      bus.i_HiLoSelE = 2'b10;
      #1 check("reset_lo", {32'b0, bus.o_ALUOutE}, 64'd0);
      bus.i_HiLoSelE = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;

      // Combinational vectors through the scoreboard queue
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         v = vecs[i];
         bus.i_SrcAE = v.srca;       bus.i_SrcBE = v.srcb;     bus.i_SignImmE = v.imm;
         bus.i_ALUOutM = v.alum;     bus.i_ResultW = v.resw;
         bus.i_ForwardAE = v.fa;     bus.i_ForwardBE = v.fb;   bus.i_ALUSrcE = v.alusrc;
         bus.i_ALUControlE = v.ctl;  bus.i_ShamtE = v.shamt;
         bus.i_RtE = v.rt;           bus.i_RdE = v.rd;         bus.i_RegDstE = v.regdst;
         bus.i_HiLoSelE = v.hilo;
         exp_q.push_back(v);
         #1;
         v = exp_q.pop_front();
         check($sformatf("vec%0d_out", i),  {32'b0, bus.o_ALUOutE},    {32'b0, v.exp_out});
         check($sformatf("vec%0d_zero", i), {63'b0, bus.o_ZeroE},      {63'b0, v.exp_zero});
         check($sformatf("vec%0d_wd", i),   {32'b0, bus.o_WriteDataE}, {32'b0, v.exp_wd});
         check($sformatf("vec%0d_wr", i),   {59'b0, bus.o_WriteRegE},  {59'b0, v.exp_wr});
      end
      drive_idle();

      // MULTU 0xFFFFFFFF x 2 with MFLO waiting in E
      start_mul(32'hFFFF_FFFF, 32'd2, 1'b0, 64'h0000_0001_FFFF_FFFE);
      wait_done(2'b10, cyc, s_miss);
      check("multu_busy_cycles", cyc, 64'd32);
      check("multu_stall_while_busy", s_miss, 64'd0);
      check("multu_stall_released", {63'b0, bus.o_StallE}, 64'd0);
      bus.i_HiLoSelE = 2'b00;
      check_hilo("multu");

      // -3 x 7, signed request
`ifdef MUL_SIGNED_EN
      exp_signed = 64'hFFFF_FFFF_FFFF_FFEB;
`else
      exp_signed = 64'h0000_0006_FFFF_FFEB;
`endif
      start_mul(32'hFFFF_FFFD, 32'd7, 1'b1, exp_signed);
      wait_done(2'b00, cyc, s_miss);
      check("mult_busy_cycles", cyc, 64'd32);
      check("mult_no_stall_alu_only", s_miss, 64'd0);
      check_hilo("mult_neg3x7");

      // Back-to-back: second start held in E while the first is busy
      @(negedge clk);
      bus.i_SrcAE = 32'd1000;
      bus.i_SrcBE = 32'd3000;
      bus.i_MulSignedE = 1'b0;
      bus.i_MulStartE = 1'b1;
      mul_q.push_back(mul_model(32'd1000, 32'd3000, 1'b0));
      @(posedge clk);
      @(negedge clk);
      bus.i_SrcAE = 32'hDEAD_BEEF;
      bus.i_SrcBE = 32'h0000_1001;
      mul_q.push_back(mul_model(32'hDEAD_BEEF, 32'h0000_1001, 1'b0));
      bus.i_HiLoSelE = 2'b01;
      #1;
      cyc = 0;
      s_miss = 0;
      h_miss = 0;
      while (bus.o_MulBusyE && cyc < 200) begin
         cyc++;
         if (bus.o_StallE !== 1'b1) s_miss++;
         if (bus.o_ALUOutE !== last_hilo[63:32]) h_miss++;
         @(negedge clk);
         #1;
      end
      check("b2b_first_busy_cycles", cyc, 64'd32);
      check("b2b_stall_held", s_miss, 64'd0);
      check("b2b_hi_held_until_done", h_miss, 64'd0);
      check("b2b_idle_no_stall", {63'b0, bus.o_StallE}, 64'd0);
      bus.i_HiLoSelE = 2'b00;
      check_hilo("b2b_first");
      @(posedge clk);
      @(negedge clk);
      bus.i_MulStartE = 1'b0;
      #1 check("b2b_second_started", {63'b0, bus.o_MulBusyE}, 64'd1);
      wait_done(2'b00, cyc, s_miss);
      check("b2b_second_busy_cycles", cyc + 0, 64'd32);
      check_hilo("b2b_second");

      // Reset in the middle of a multiply
      start_mul(32'h0001_2345, 32'h0000_6789, 1'b0, mul_model(32'h0001_2345, 32'h0000_6789, 1'b0));
      repeat (10) @(negedge clk);
      #1 rst_n = 1'b0;
      #1 check("rst_mid_busy", {63'b0, bus.o_MulBusyE}, 64'd0);
      bus.i_HiLoSelE = 2'b01;
      #1 check("rst_mid_hi", {32'b0, bus.o_ALUOutE}, 64'd0);
      bus.i_HiLoSelE = 2'b10;
      #1 check("rst_mid_lo", {32'b0, bus.o_ALUOutE}, 64'd0);
      bus.i_HiLoSelE = 2'b00;
      mul_q.delete();
      last_hilo = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // Zero operand still takes the full iteration count
      start_mul(32'd0, 32'd5, 1'b0, 64'd0);
      wait_done(2'b00, cyc, s_miss);
      check("zero_op_busy_cycles", cyc, 64'd32);
      check_hilo("zero_op");

      // D/E flush while busy does not disturb the multiply
      start_mul(32'd123456, 32'd654321, 1'b0, mul_model(32'd123456, 32'd654321, 1'b0));
      drive_idle();
      wait_done(2'b00, cyc, s_miss);
      check("flush_busy_cycles", cyc, 64'd32);
      check_hilo("flush");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
